fir3_q26_core: RTL and testbench

Three-tap fixed-point FIR filter core operating on signed Q2.6 samples (8-bit: 2 integer bits including sign, 6 fractional bits). It is built from three reusable primitives: a shift-register delay (`my_srl`), a saturating fixed-point multiplier (`fpmult`) and a saturating fixed-point adder (`fpadder`). It sits in the sample-rate signal path, takes one sample per enabled clock and produces one filtered sample per enabled clock. The coefficients can be reloaded at run time.

---
 rtl/fir_q26_pkg.sv | 15 +
 rtl/fir3_q26_core_if.sv | 13 +
 rtl/fir3_q26_core_prims.sv | 91 +++++++++
 rtl/fir3_q26_core.sv | 66 ++++++
 tb/tb_fir3_q26_core.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fir_q26_pkg.sv
// Shared Q2.6 types and constants for the three-tap FIR core.
package fir_q26_pkg;
   localparam int WL = 8;
   localparam int WI = 2;
   localparam int WF = 6;

   typedef logic [WL-1:0] q26_t;

   localparam q26_t H0_RST = 8'hEB;
   localparam q26_t H1_RST = 8'h33;
   localparam q26_t H2_RST = 8'h1A;

   localparam q26_t Q_MAX = 8'h7F;
   localparam q26_t Q_MIN = 8'h80;
endpackage

// File: rtl/fir3_q26_core_if.sv
// Sample / coefficient bus between the signal path and the FIR core.
interface fir3_q26_core_if;
   import fir_q26_pkg::*;

   q26_t x;
   q26_t h;
   logic load;
   logic enable;
   q26_t y;

   modport master (output x, h, load, enable, input y);
   modport slave (input x, h, load, enable, output y);
endinterface

// File: rtl/fir3_q26_core_prims.sv
// Reusable fixed-point primitives: delay line, saturating multiply
// and saturating add.
module my_srl #(
   parameter int WL    = 8,
   parameter int DELAY = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [WL-1:0] d,
   output logic [WL-1:0] q
);
   logic [WL-1:0] sr [DELAY+1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= DELAY; i++) sr[i] <= '0;
      end else if (en) begin
         sr[0] <= d;
         for (int i = 1; i <= DELAY; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[DELAY];
endmodule

module fpmult #(
   parameter int WL = 8,
   parameter int WF = 6
) (
   input  logic [WL-1:0] a,
   input  logic [WL-1:0] b,
   output logic [WL-1:0] p
);
   localparam int PW   = 2 * WL;
   localparam int MAXI = (1 << (WL - 1)) - 1;
   localparam int MINI = -(1 << (WL - 1));
   localparam logic signed [PW-1:0] MAXV = PW'(MAXI);
   localparam logic signed [PW-1:0] MINV = PW'(MINI);

   logic signed [PW-1:0] full;
   logic signed [PW-1:0] sh;

   // Arithmetic shift floors toward -inf before clamping.
   assign full = $signed(a) * $signed(b);
   assign sh   = full >>> WF;

   always_comb begin
      p = sh[WL-1:0];
      if (sh > MAXV) p = MAXV[WL-1:0];
      else if (sh < MINV) p = MINV[WL-1:0];
   end
endmodule

module fpadder #(
   parameter int WI1 = 2,
   parameter int WF1 = 6,
   parameter int WI2 = 2,
   parameter int WF2 = 6,
   parameter int WIO = 2,
   parameter int WFO = 6
) (
   input  logic [WI1+WF1-1:0] a,
   input  logic [WI2+WF2-1:0] b,
   output logic [WIO+WFO-1:0] s
);
   localparam int WL1 = WI1 + WF1;
   localparam int WL2 = WI2 + WF2;
   localparam int WLO = WIO + WFO;
   localparam int AR  = (WF1 > WFO) ? WF1 - WFO : 0;
   localparam int AL  = (WFO > WF1) ? WFO - WF1 : 0;
   localparam int BR  = (WF2 > WFO) ? WF2 - WFO : 0;
   localparam int BL  = (WFO > WF2) ? WFO - WF2 : 0;
   localparam logic signed [31:0] MAXV = (32'sd1 <<< (WLO - 1)) - 32'sd1;
   localparam logic signed [31:0] MINV = -(32'sd1 <<< (WLO - 1));

   logic signed [31:0] a_w;
   logic signed [31:0] b_w;
   logic signed [31:0] sum;

   // Wide sign extension leaves ample headroom for the carry bit.
   assign a_w = ($signed({{(32-WL1){a[WL1-1]}}, a}) >>> AR) <<< AL;
   assign b_w = ($signed({{(32-WL2){b[WL2-1]}}, b}) >>> BR) <<< BL;
   assign sum = a_w + b_w;

   always_comb begin
      s = sum[WLO-1:0];
      if (sum > MAXV) s = MAXV[WLO-1:0];
      else if (sum < MINV) s = MINV[WLO-1:0];
   end
endmodule

// File: rtl/fir3_q26_core.sv
// Three-tap Q2.6 FIR: combinational multiply/add tree between the
// delay taps and a single output register; run-time coefficient load.
module fir3_q26_core
   import fir_q26_pkg::*;
#(
   parameter int P_WL = WL,
   parameter int P_WI = WI,
   parameter int P_WF = WF
) (
   input logic         CLK,
   input logic         RST,
   fir3_q26_core_if.slave bus
);
   q26_t h0, h1, h2;
   q26_t tap1, tap2;
   q26_t p0, p1, p2;
   q26_t s01, s012;

   my_srl #(.WL(P_WL), .DELAY(0)) u_srl1 (
      .clk (CLK),
      .rst (RST),
      .en  (bus.enable),
      .d   (bus.x),
      .q   (tap1)
   );

   my_srl #(.WL(P_WL), .DELAY(0)) u_srl2 (
      .clk (CLK),
      .rst (RST),
      .en  (bus.enable),
      .d   (tap1),
      .q   (tap2)
   );

   fpmult #(.WL(P_WL), .WF(P_WF)) u_m0 (.a(bus.x), .b(h0), .p(p0));
   fpmult #(.WL(P_WL), .WF(P_WF)) u_m1 (.a(tap1), .b(h1), .p(p1));
   fpmult #(.WL(P_WL), .WF(P_WF)) u_m2 (.a(tap2), .b(h2), .p(p2));

   fpadder #(
      .WI1(P_WI), .WF1(P_WF), .WI2(P_WI),
      .WF2(P_WF), .WIO(P_WI), .WFO(P_WF)
   ) u_a0 (.a(p0), .b(p1), .s(s01));

   fpadder #(
      .WI1(P_WI), .WF1(P_WF), .WI2(P_WI),
      .WF2(P_WF), .WIO(P_WI), .WFO(P_WF)
   ) u_a1 (.a(s01), .b(p2), .s(s012));

   // Bank shifts independently of enable; y uses pre-load values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         h0 <= H0_RST;
         h1 <= H1_RST;
         h2 <= H2_RST;
      end else if (bus.load) begin
         h0 <= bus.h;
         h1 <= h0;
         h2 <= h1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) bus.y <= '0;
      else if (bus.enable) bus.y <= s012;
   end
endmodule

// File: tb/tb_fir3_q26_core.sv
// Randomized and directed bench for fir3_q26_core against an
// integer-arithmetic reference of the filter equation.
module tb_fir3_q26_core;
   import fir_q26_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;

   int   xh [2];
   int   cf [3];
   int   ym;

   fir3_q26_core_if bus ();

   fir3_q26_core dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic int s8(input logic [7:0] v);
      return int'($signed(v));
   endfunction

   function automatic int qmul(input int a, input int b);
      return sat((a * b) >>> 6);
   endfunction

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      xh[0] = 0;
      xh[1] = 0;
      cf[0] = s8(H0_RST);
      cf[1] = s8(H1_RST);
      cf[2] = s8(H2_RST);
      ym = 0;
   endtask

   task automatic step(input logic [7:0] x, input logic [7:0] h,
                       input logic ld, input logic en, input logic r);
      int xv;
      rst        = r;
      bus.x      = x;
      bus.h      = h;
      bus.load   = ld;
      bus.enable = en;
      @(posedge clk);
      #1;
      xv = s8(x);
      if (r) begin
         model_reset();
      end else begin
         if (en) begin
            ym = sat(sat(qmul(xv, cf[0]) + qmul(xh[0], cf[1]))
                     + qmul(xh[1], cf[2]));
            xh[1] = xh[0];
            xh[0] = xv;
         end
         if (ld) begin
            cf[2] = cf[1];
            cf[1] = cf[0];
            cf[0] = s8(h);
         end
      end
      chk("model", bus.y, 8'(ym));
   endtask

   task automatic do_reset();
      step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [7:0] exp_imp [4];
      logic [7:0] exp_stp [5];
      exp_imp = '{8'hEB, 8'h33, 8'h1A, 8'h00};
      exp_stp = '{8'h2A, 8'hC4, 8'h90, 8'h90, 8'h90};
      model_reset();

      do_reset();
      do_reset();
      chk("reset_y", bus.y, 8'h00);

      // impulse
      for (int i = 0; i < 4; i++) begin
         step(i == 0 ? 8'h40 : 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
         chk("impulse", bus.y, exp_imp[i]);
      end

      // negative full-scale step
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
         chk("step_neg", bus.y, exp_stp[i]);
      end

      // truncation toward -inf
      do_reset();
      step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("trunc0", bus.y, 8'hFF);
      step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("trunc1", bus.y, 8'h00);
      step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("trunc2", bus.y, 8'h00);

      // positive saturation
      do_reset();
      for (int i = 0; i < 3; i++) step(8'h00, 8'h7F, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(8'h7F, 8'h00, 1'b0, 1'b1, 1'b0);
         chk("sat_pos", bus.y, 8'h7F);
      end

      // negative saturation
      do_reset();
      for (int i = 0; i < 3; i++) step(8'h00, 8'h7F, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
         chk("sat_neg", bus.y, 8'h80);
      end

      // enable gating
      do_reset();
      step(8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
         chk("gate_hold", bus.y, 8'hEB);
      end
      step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("gate_1", bus.y, 8'h33);
      step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("gate_2", bus.y, 8'h1A);

      // mid-stream reset after a load restores defaults
      step(8'h00, 8'h20, 1'b1, 1'b0, 1'b0);
      step(8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
      step(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("mid_rst", bus.y, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step(i == 0 ? 8'h40 : 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
         chk("post_rst", bus.y, exp_imp[i]);
      end

      // load and enable together use pre-load coefficients
      step(8'h40, 8'h10, 1'b1, 1'b1, 1'b0);
      chk("ld_en", bus.y, 8'hEB);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(8'($urandom), 8'($urandom),
              $urandom_range(7) == 0,
              $urandom_range(3) != 0,
              $urandom_range(49) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
